// File: rtl/dma_desc_sched.sv
// dma_desc_sched: round-robin multi-channel descriptor scheduler feeding a single DMA engine
// Ports: push_valid_i/push_desc_i/push_ready_o fill the per-channel descriptor FIFOs;
//        eng_valid_o/eng_ready_i/eng_desc_o/eng_ch_o issue one descriptor to the engine;
//        eng_done_i/eng_err_i report completion; clr_i is W1C for the sticky status;
//        ch_active_o/ch_done_o/ch_err_o/err_info_o/irq_o expose per-channel status.
package dma_desc_pkg;
    localparam int AddrWidth = 32;
    localparam int StrbWidth = 4;
    localparam int OffsetWidth = $clog2(StrbWidth);
    typedef enum logic [1:0] {DMA_NO_ERR, DMA_AXI_RD_ERR, DMA_AXI_WR_ERR, DMA_UNALIGNED_ERR} dma_err_src_e;
    typedef struct packed {
        logic [AddrWidth-1:0] src_addr;
        logic [AddrWidth-1:0] dst_addr;
        logic [31:0]          num_bytes;
    } s_dma_desc_t;
    typedef struct packed {
        logic                 valid;
        dma_err_src_e         src;
        logic [AddrWidth-1:0] addr;
    } s_dma_error_t;
endpackage

module dma_desc_sched
    import dma_desc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DESC_DEPTH = 4,
    parameter int ALIGN_CHECK = 1,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PW = $clog2(DESC_DEPTH),
    localparam int DW = $bits(s_dma_desc_t)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    push_valid_i,
    input  logic [NUM_CH*DW-1:0] push_desc_i,
    output logic [NUM_CH-1:0]    push_ready_o,
    output logic                 eng_valid_o,
    input  logic                 eng_ready_i,
    output s_dma_desc_t          eng_desc_o,
    output logic [CW-1:0]        eng_ch_o,
    input  logic                 eng_done_i,
    input  s_dma_error_t         eng_err_i,
    input  logic [NUM_CH-1:0]    clr_i,
    output logic [NUM_CH-1:0]    ch_active_o,
    output logic [NUM_CH-1:0]    ch_done_o,
    output logic [NUM_CH-1:0]    ch_err_o,
    output s_dma_error_t         err_info_o,
    output logic                 irq_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    state_e               r_state, w_state_nx;
    s_dma_desc_t          r_mem [NUM_CH][DESC_DEPTH];
    logic [PW-1:0]        r_wp [NUM_CH];
    logic [PW-1:0]        r_rp [NUM_CH];
    logic [PW:0]          r_cnt [NUM_CH];
    logic [CW-1:0]        r_ptr, w_ptr_nx, r_ch, w_g;
    logic [CW:0]          w_k;
    s_dma_desc_t          r_desc, w_head;
    logic [NUM_CH-1:0]    r_done, r_err, w_elig, w_push, w_pop, w_flush, w_set_done, w_set_err;
    logic [AddrWidth-1:0] r_err_addr, w_err_addr;
    dma_err_src_e         r_err_src, w_err_src;
    logic                 w_any, w_err_ld, w_ld_desc, w_src_bad, w_dst_bad;

    // a halted channel (sticky error) neither accepts pushes nor competes for the engine
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_elig[c] = (r_cnt[c] != '0) && !r_err[c];
            push_ready_o[c] = (r_cnt[c] < (PW+1)'(DESC_DEPTH)) && !r_err[c];
            w_push[c] = push_valid_i[c] && push_ready_o[c];
            ch_active_o[c] = (r_cnt[c] != '0) || (r_state != IDLE && r_ch == CW'(c));
        end
    end

    // scan downwards so the eligible channel closest to r_ptr is the one left in w_g
    always_comb begin
        w_any = 1'b0;
        w_g = '0;
        w_k = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_k = {1'b0, r_ptr} + (CW+1)'(i);
            if (w_k >= (CW+1)'(NUM_CH)) w_k = w_k - (CW+1)'(NUM_CH);
            if (w_elig[w_k[CW-1:0]]) begin
                w_any = 1'b1;
                w_g = w_k[CW-1:0];
            end
        end
    end

    assign w_head = r_mem[w_g][r_rp[w_g]];
    assign w_src_bad = (ALIGN_CHECK != 0) && (w_head.src_addr[OffsetWidth-1:0] != '0);
    assign w_dst_bad = (ALIGN_CHECK != 0) && (w_head.dst_addr[OffsetWidth-1:0] != '0);

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx = r_ptr;
        w_pop = '0;
        w_flush = '0;
        w_set_done = '0;
        w_set_err = '0;
        w_err_ld = 1'b0;
        w_err_addr = r_err_addr;
        w_err_src = r_err_src;
        w_ld_desc = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_pop[w_g] = 1'b1;
                w_ptr_nx = (w_g == CW'(NUM_CH - 1)) ? '0 : w_g + 1'b1;
                if (w_head.num_bytes == '0) begin
                    w_set_done[w_g] = 1'b1;
                end else if (w_src_bad || w_dst_bad) begin
                    w_flush[w_g] = 1'b1;
                    w_set_err[w_g] = 1'b1;
                    w_err_ld = 1'b1;
                    w_err_src = DMA_UNALIGNED_ERR;
                    w_err_addr = w_src_bad ? w_head.src_addr : w_head.dst_addr;
                end else begin
                    w_ld_desc = 1'b1;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: w_state_nx = eng_ready_i ? WAIT : ISSUE;
            WAIT: if (eng_err_i.valid) begin
                w_flush[r_ch] = 1'b1;
                w_set_err[r_ch] = 1'b1;
                w_err_ld = 1'b1;
                w_err_src = eng_err_i.src;
                w_err_addr = eng_err_i.addr;
                w_state_nx = IDLE;
            end else if (eng_done_i) begin
                w_set_done[r_ch] = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (w_push[c]) r_mem[c][r_wp[c]] <= push_desc_i[c*DW +: DW];
    end

    // a flush drops everything queued, including a push landing on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= '0;
            r_ch <= '0;
            r_desc <= '0;
            r_done <= '0;
            r_err <= '0;
            r_err_addr <= '0;
            r_err_src <= DMA_NO_ERR;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wp[c] <= '0;
                r_rp[c] <= '0;
                r_cnt[c] <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_ptr <= w_ptr_nx;
            if (w_ld_desc) begin
                r_desc <= w_head;
                r_ch <= w_g;
            end
            r_done <= w_set_done | (r_done & ~clr_i);
            r_err <= w_set_err | (r_err & ~clr_i);
            if (w_err_ld) begin
                r_err_addr <= w_err_addr;
                r_err_src <= w_err_src;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_flush[c]) begin
                    r_rp[c] <= r_wp[c];
                    r_cnt[c] <= '0;
                end else begin
                    if (w_push[c]) r_wp[c] <= r_wp[c] + 1'b1;
                    if (w_pop[c]) r_rp[c] <= r_rp[c] + 1'b1;
                    r_cnt[c] <= r_cnt[c] + (PW+1)'(w_push[c]) - (PW+1)'(w_pop[c]);
                end
            end
        end
    end

    assign eng_valid_o = (r_state == ISSUE);
    assign eng_desc_o = r_desc;
    assign eng_ch_o = r_ch;
    assign ch_done_o = r_done;
    assign ch_err_o = r_err;
    assign err_info_o = '{valid: |r_err, src: r_err_src, addr: r_err_addr};
    assign irq_o = |(r_done | r_err);
endmodule

// File: tb/tb_dma_desc_sched.sv
// tb_dma_desc_sched: self-checking bench for dma_desc_sched (vector table, directed sequences, random vs queue model)
module tb_dma_desc_sched;
    import dma_desc_pkg::*;
    localparam int NCH = 4;
    localparam int DEPTH = 4;
    localparam int DW = $bits(s_dma_desc_t);

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     push_valid, push_ready, clr, ch_active, ch_done, ch_err;
    s_dma_desc_t        push_desc [NCH];
    logic [NCH*DW-1:0]  push_desc_flat;
    logic               eng_valid, eng_ready, eng_done, irq;
    s_dma_desc_t        eng_desc;
    logic [1:0]         eng_ch;
    s_dma_error_t       eng_err, err_info;
    s_dma_desc_t        mq [NCH][$];
    int                 n_chk = 0;
    int                 n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < NCH; c++) push_desc_flat[c*DW +: DW] = push_desc[c];
    end

    dma_desc_sched #(.NUM_CH(NCH), .DESC_DEPTH(DEPTH), .ALIGN_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .push_valid_i(push_valid), .push_desc_i(push_desc_flat), .push_ready_o(push_ready),
        .eng_valid_o(eng_valid), .eng_ready_i(eng_ready), .eng_desc_o(eng_desc), .eng_ch_o(eng_ch),
        .eng_done_i(eng_done), .eng_err_i(eng_err), .clr_i(clr),
        .ch_active_o(ch_active), .ch_done_o(ch_done), .ch_err_o(ch_err),
        .err_info_o(err_info), .irq_o(irq)
    );

    typedef struct {
        logic [31:0]  src, dst, len;
        bit           eerr, both;
        dma_err_src_e esrc;
        logic [31:0]  eaddr;
        bit           x_issue, x_done, x_err;
        dma_err_src_e x_src;
        logic [31:0]  x_addr;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic s_dma_desc_t mk(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        return '{src_addr: s, dst_addr: d, num_bytes: n};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        push_valid = '0;
        clr = '0;
        eng_ready = 1'b0;
        eng_done = 1'b0;
        eng_err = '0;
        for (int c = 0; c < NCH; c++) push_desc[c] = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string name);
        check({name, " eng_valid"}, eng_valid, 0);
        check({name, " push_ready"}, push_ready, 4'hF);
        check({name, " ch_active"}, ch_active, 0);
        check({name, " ch_done"}, ch_done, 0);
        check({name, " ch_err"}, ch_err, 0);
        check({name, " err_info"}, err_info, 0);
        check({name, " irq"}, irq, 0);
        check({name, " eng_desc"}, eng_desc, 0);
        check({name, " eng_ch"}, eng_ch, 0);
    endtask

    task automatic push1(input int c, input s_dma_desc_t d);
        push_desc[c] = d;
        push_valid[c] = 1'b1;
        tick();
        push_valid[c] = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (eng_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve(input string name, input int exp_ch, input logic [31:0] exp_src, input bit err, input s_dma_error_t e);
        bit ok;
        wait_valid(ok);
        check({name, " valid seen"}, ok, 1);
        if (!ok) return;
        check({name, " ch"}, eng_ch, exp_ch);
        check({name, " src"}, eng_desc.src_addr, exp_src);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        tick();
        tick();
        if (err) eng_err = e;
        else eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_err = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    initial begin
        bit issued, ok, busy;
        int acc, dly, npush, niss;
        logic [NCH-1:0] used;
        s_dma_desc_t d;

        rst = 1'b1;
        push_valid = '0;
        clr = '0;
        eng_ready = 1'b0;
        eng_done = 1'b0;
        eng_err = '0;
        for (int c = 0; c < NCH; c++) push_desc[c] = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        tbl[0] = '{32'h1000, 32'h2000, 32'd256, 1'b0, 1'b0, DMA_NO_ERR, 32'h0, 1'b1, 1'b1, 1'b0, DMA_NO_ERR, 32'h0};
        tbl[1] = '{32'h1000, 32'h2000, 32'd0, 1'b0, 1'b0, DMA_NO_ERR, 32'h0, 1'b0, 1'b1, 1'b0, DMA_NO_ERR, 32'h0};
        tbl[2] = '{32'h1004 + 32'h1, 32'h2000, 32'd16, 1'b0, 1'b0, DMA_NO_ERR, 32'h0, 1'b0, 1'b0, 1'b1, DMA_UNALIGNED_ERR, 32'h1005};
        tbl[3] = '{32'h1000, 32'h2002, 32'd16, 1'b0, 1'b0, DMA_NO_ERR, 32'h0, 1'b0, 1'b0, 1'b1, DMA_UNALIGNED_ERR, 32'h2002};
        tbl[4] = '{32'h1001, 32'h2003, 32'd16, 1'b0, 1'b0, DMA_NO_ERR, 32'h0, 1'b0, 1'b0, 1'b1, DMA_UNALIGNED_ERR, 32'h1001};
        tbl[5] = '{32'h1100, 32'h2200, 32'd64, 1'b1, 1'b0, DMA_AXI_RD_ERR, 32'h3040, 1'b1, 1'b0, 1'b1, DMA_AXI_RD_ERR, 32'h3040};
        tbl[6] = '{32'h1200, 32'h2400, 32'd64, 1'b1, 1'b1, DMA_AXI_WR_ERR, 32'h5550, 1'b1, 1'b0, 1'b1, DMA_AXI_WR_ERR, 32'h5550};
        for (int i = 0; i < 7; i++) begin
            push1(0, mk(tbl[i].src, tbl[i].dst, tbl[i].len));
            issued = 1'b0;
            for (int k = 0; k < 4 && !issued; k++) begin
                if (eng_valid) issued = 1'b1;
                else tick();
            end
            if (issued) begin
                eng_ready = 1'b1;
                tick();
                eng_ready = 1'b0;
                tick();
                tick();
                eng_done = !tbl[i].eerr || tbl[i].both;
                eng_err = tbl[i].eerr ? '{valid: 1'b1, src: tbl[i].esrc, addr: tbl[i].eaddr} : '0;
                tick();
                eng_done = 1'b0;
                eng_err = '0;
            end
            tick();
            tick();
            check($sformatf("vec%0d issue", i), issued, tbl[i].x_issue);
            check($sformatf("vec%0d done", i), ch_done[0], tbl[i].x_done);
            check($sformatf("vec%0d err", i), ch_err[0], tbl[i].x_err);
            check($sformatf("vec%0d err valid", i), err_info.valid, tbl[i].x_err);
            check($sformatf("vec%0d irq", i), irq, tbl[i].x_done | tbl[i].x_err);
            check($sformatf("vec%0d push_ready", i), push_ready[0], !tbl[i].x_err);
            if (tbl[i].x_err) begin
                check($sformatf("vec%0d err src", i), err_info.src, tbl[i].x_src);
                check($sformatf("vec%0d err addr", i), err_info.addr, tbl[i].x_addr);
            end
            clr = 4'b0001;
            tick();
            clr = '0;
            check($sformatf("vec%0d clr status", i), {ch_done[0], ch_err[0], irq, err_info.valid}, 4'b0000);
            check($sformatf("vec%0d clr ready", i), push_ready[0], 1);
        end

        do_reset();
        push1(0, mk(32'h1000, 32'h2000, 32'd256));
        check("t1 valid at N+1", eng_valid, 0);
        tick();
        check("t1 valid at N+2", eng_valid, 1);
        check("t1 desc", eng_desc, mk(32'h1000, 32'h2000, 32'd256));
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("t1 ch_done", ch_done, 4'b0001);
        check("t1 irq", irq, 1);
        clr = 4'b0001;
        tick();
        clr = '0;
        check("t1 clr ch_done", ch_done, 0);
        check("t1 clr irq", irq, 0);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) push_desc[c] = mk((c + 1) * 32'h1000 + r * 32'h80, 32'h8000, 32'd32);
            push_valid = 4'hF;
            tick();
        end
        push_valid = '0;
        for (int k = 0; k < 8; k++)
            serve($sformatf("t2 issue%0d", k), k % 4, ((k % 4) + 1) * 32'h1000 + (k / 4) * 32'h80, 1'b0, '0);
        tick();
        check("t2 ch_active", ch_active, 0);
        check("t2 ch_done", ch_done, 4'hF);

        do_reset();
        acc = 0;
        for (int k = 0; k < 8 && push_ready[1]; k++) begin
            push_desc[1] = mk(32'h4000 + acc * 32'h100, 32'h8000, 32'd64);
            push_valid[1] = 1'b1;
            tick();
            acc++;
        end
        push_valid[1] = 1'b0;
        check("t3 accepted", acc, DEPTH + 1);
        check("t3 push_ready", push_ready[1], 0);
        for (int k = 0; k < 4; k++) begin
            check("t3 stall valid", eng_valid, 1);
            check("t3 stall desc", eng_desc.src_addr, 32'h4000);
            tick();
        end
        for (int k = 0; k <= DEPTH; k++)
            serve($sformatf("t3 drain%0d", k), 1, 32'h4000 + k * 32'h100, 1'b0, '0);
        tick();
        check("t3 drained", ch_active, 0);

        do_reset();
        push_desc[2] = mk(32'h6000, 32'h8000, 32'd64);
        push_desc[3] = mk(32'h7000, 32'h8000, 32'd64);
        push_valid = 4'b1100;
        tick();
        push_valid = '0;
        push1(2, mk(32'h6100, 32'h8000, 32'd64));
        push1(2, mk(32'h6200, 32'h8000, 32'd64));
        serve("t4 err", 2, 32'h6000, 1'b1, '{valid: 1'b1, src: DMA_AXI_RD_ERR, addr: 32'h3040});
        check("t4 ch_err", ch_err, 4'b0100);
        check("t4 halted", push_ready[2], 0);
        check("t4 flushed", ch_active[2], 0);
        check("t4 err addr", err_info.addr, 32'h3040);
        check("t4 err src", err_info.src, DMA_AXI_RD_ERR);
        check("t4 err valid", err_info.valid, 1);
        push1(2, mk(32'h6300, 32'h8000, 32'd64));
        check("t4 halted push", ch_active[2], 0);
        serve("t4 other", 3, 32'h7000, 1'b0, '0);
        check("t4 ch_done", ch_done, 4'b1000);
        clr = 4'b0100;
        tick();
        clr = '0;
        check("t4 clr err", ch_err, 0);
        check("t4 clr ready", push_ready[2], 1);
        check("t4 clr valid", err_info.valid, 0);
        check("t4 done kept", ch_done, 4'b1000);

        do_reset();
        push1(0, mk(32'h9000, 32'h8000, 32'd64));
        push1(0, mk(32'h9100, 32'h8000, 32'd64));
        push1(0, mk(32'h9200, 32'h8000, 32'd64));
        wait_valid(ok);
        check("t6 issue", ok, 1);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("t6 mid reset");
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        check("t6 done ignored", ch_done, 0);
        check("t6 idle", eng_valid, 0);

        do_reset();
        busy = 1'b0;
        dly = 0;
        npush = 0;
        niss = 0;
        used = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                push_valid[c] = (cyc < 1500) && ($urandom % 4 == 0);
                push_desc[c] = mk({$urandom, 2'b00} & 32'hFFFF_FFFC, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom_range(1, 4096));
            end
            eng_ready = $urandom % 2;
            eng_done = 1'b0;
            if (busy) begin
                if (dly == 0) begin
                    eng_done = 1'b1;
                    busy = 1'b0;
                end else dly--;
            end
            @(negedge clk);
            for (int c = 0; c < NCH; c++)
                if (push_valid[c] && push_ready[c]) begin
                    mq[c].push_back(push_desc[c]);
                    npush++;
                end
            if (eng_valid && eng_ready) begin
                if (mq[eng_ch].size() == 0) check("rnd issue from empty channel", 0, 1);
                else begin
                    d = mq[eng_ch].pop_front();
                    check($sformatf("rnd desc ch%0d", eng_ch), eng_desc, d);
                end
                busy = 1'b1;
                dly = $urandom_range(0, 3);
                niss++;
                used[eng_ch] = 1'b1;
            end
            tick();
            if (cyc >= 1500 && !busy && !eng_valid && ch_active == '0 &&
                mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && mq[3].size() == 0) break;
        end
        push_valid = '0;
        eng_done = 1'b0;
        check("rnd drained", mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size(), 0);
        check("rnd issue count", niss, npush);
        check("rnd ch_done", ch_done, used);
        check("rnd ch_active", ch_active, 0);
        check("rnd no err", ch_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
